img_rle_loader: RTL and testbench

IMG_RLE_LOADER -- requirements
Module: img_rle_loader

---
 rtl/img_rle_loader.sv | 169 ++++++++++++++++
 tb/tb_img_rle_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_rle_loader.sv
// Run-length decoder for the image section of a download stream. Each decoded
// pixel becomes a framebuffer write held on fb_we until fb_ack accepts it.
module img_rle_loader #(
    parameter int unsigned       ADDR_W  = 18,
    parameter logic [ADDR_W-1:0] FB_LAST = {ADDR_W{1'b1}}
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              image,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_data,
    output logic              fb_we,
    input  logic              fb_ack,
    output logic              done,
    output logic              overflow,
    output logic              error
);

    typedef enum logic [2:0] {StIdle, StCtrl, StLit, StRepVal, StRepWr, StDone} state_e;

    // One extra address bit so tracking can rest at FB_LAST+1 without wrapping.
    localparam logic [ADDR_W:0] LastExt = {1'b0, FB_LAST};
    localparam logic [ADDR_W:0] AddrOne = {{ADDR_W{1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic            image_q;
    logic [ADDR_W:0] addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic            we_q, we_d;
    logic [6:0]      cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic            err_q, err_d;
    logic            trunc_q, trunc_d;

    logic            rise, fall, byte_v, take, ack, in_range, busy, ending;
    logic [ADDR_W:0] addr_inc;

    assign rise     = image & ~image_q;
    assign fall     = ~image & image_q;
    assign byte_v   = image & ioctl_wr;
    assign take     = byte_v & ~ioctl_wait;
    assign ack      = we_q & fb_ack;
    assign in_range = (addr_q <= LastExt);
    assign addr_inc = ack ? addr_q + AddrOne : addr_q;
    assign busy     = (state_q == StLit) || (state_q == StRepVal) || (state_q == StRepWr);
    // A truncated run keeps ending asserted until its held write is accepted.
    assign ending   = fall | trunc_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= StIdle;
            image_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            image_q <= image;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            trunc_q <= trunc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        trunc_d = trunc_q;
        if (busy && ending) begin
            err_d = 1'b1;
            if (we_q && !fb_ack) begin
                trunc_d = 1'b1;
            end else begin
                addr_d  = addr_inc;
                we_d    = 1'b0;
                trunc_d = 1'b0;
                done_d  = 1'b1;
                state_d = StDone;
            end
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (rise) begin
                        addr_d  = '0;
                        done_d  = 1'b0;
                        ovf_d   = 1'b0;
                        err_d   = 1'b0;
                        state_d = StCtrl;
                    end
                end
                StCtrl: begin
                    if (fall) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else if (take) begin
                        cnt_d   = ioctl_dout[6:0];
                        state_d = ioctl_dout[7] ? StRepVal : StLit;
                    end
                end
                StLit: begin
                    if (take) data_d = ioctl_dout;
                    if (take && in_range) begin
                        we_d = 1'b1;
                    end else if (ack || take) begin
                        // Out-of-range literal counts as accepted on arrival.
                        we_d   = 1'b0;
                        addr_d = addr_inc;
                        if (!ack) ovf_d = 1'b1;
                        if (cnt_q == '0) state_d = StCtrl;
                        else cnt_d = cnt_q - 7'd1;
                    end
                end
                StRepVal: begin
                    if (take) begin
                        data_d  = ioctl_dout;
                        we_d    = in_range;
                        state_d = StRepWr;
                    end
                end
                StRepWr: begin
                    if (ack || !we_q) begin
                        addr_d = addr_inc;
                        if (!we_q) ovf_d = 1'b1;
                        if (cnt_q == '0) begin
                            we_d    = 1'b0;
                            state_d = StCtrl;
                        end else begin
                            cnt_d = cnt_q - 7'd1;
                            we_d  = (addr_inc <= LastExt);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        if (byte_v && ioctl_wait) err_d = 1'b1;
    end

    always_comb begin
        ioctl_wait = we_q || (state_q == StRepWr);
        fb_addr    = addr_q[ADDR_W-1:0];
        fb_data    = data_q;
        fb_we      = we_q;
        done       = done_q;
        overflow   = ovf_q;
        error      = err_q;
    end

endmodule

// File: tb/tb_img_rle_loader.sv
// Bench for img_rle_loader: directed scenarios plus random RLE streams, checked
// against a stream-level decode model on a full-size and a tiny framebuffer.
module tb_img_rle_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, image, ioctl_wr;
    logic [7:0] ioctl_dout;
    logic       fb_ack;
    logic        m_wait, m_we, m_done, m_ovf, m_err;
    logic [17:0] m_addr;
    logic [7:0]  m_data;
    logic        s_wait, s_we, s_done, s_ovf, s_err;
    logic [17:0] s_addr;
    logic [7:0]  s_data;

    img_rle_loader #(.ADDR_W(18)) u_dut (
        .clk_sys(clk), .reset(reset), .image(image), .ioctl_wr(ioctl_wr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(m_wait), .fb_addr(m_addr), .fb_data(m_data),
        .fb_we(m_we), .fb_ack(fb_ack), .done(m_done), .overflow(m_ovf), .error(m_err)
    );

    img_rle_loader #(.ADDR_W(18), .FB_LAST(18'd3)) u_small (
        .clk_sys(clk), .reset(reset), .image(image), .ioctl_wr(ioctl_wr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(s_wait), .fb_addr(s_addr), .fb_data(s_data),
        .fb_we(s_we), .fb_ack(fb_ack), .done(s_done), .overflow(s_ovf), .error(s_err)
    );

    typedef struct packed {logic [17:0] a; logic [7:0] d;} wr_t;

    wr_t        mq[$], sq[$], em[$], es[$];
    logic [7:0] stream[$];
    bit         e_ovf_m, e_ovf_s;
    int         checks = 0;
    int         errors = 0;
    int         stab_bad = 0;
    int         s_bad_we = 0;

    // 0: ack every cycle, 1: every 3rd cycle, 2: random, 3: driven by hand
    int   ack_mode = 0;
    logic ack_man = 1'b0;
    logic ack_gen = 1'b0;
    int   ack_cnt = 0;
    assign fb_ack = (ack_mode == 3) ? ack_man : ack_gen;

    always @(negedge clk) begin
        ack_cnt <= (ack_cnt == 2) ? 0 : ack_cnt + 1;
        case (ack_mode)
            0:       ack_gen <= 1'b1;
            1:       ack_gen <= (ack_cnt == 2);
            default: ack_gen <= 1'($urandom_range(0, 1));
        endcase
    end

    logic        p_pend = 1'b0;
    logic [17:0] p_addr = '0;
    logic [7:0]  p_data = '0;
    always @(posedge clk) begin
        if (!reset && m_we && fb_ack) mq.push_back({m_addr, m_data});
        if (!reset && s_we && fb_ack) sq.push_back({s_addr, s_data});
        if (!reset && s_we && s_addr > 18'd3) s_bad_we <= s_bad_we + 1;
        if (!reset && p_pend && (m_we !== 1'b1 || m_addr !== p_addr || m_data !== p_data))
            stab_bad <= stab_bad + 1;
        p_pend <= !reset && m_we && !fb_ack;
        p_addr <= m_addr;
        p_data <= m_data;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Decode the stream from the format rules alone, for both framebuffer sizes.
    task automatic build_expect();
        int          i;
        int unsigned addr;
        int          len;
        logic [7:0]  c, v;
        wr_t         w;
        em.delete(); es.delete();
        e_ovf_m = 0; e_ovf_s = 0;
        i = 0; addr = 0; v = 8'h00;
        while (i < stream.size()) begin
            c = stream[i]; i++;
            len = int'(c[6:0]) + 1;
            if (c[7]) begin v = stream[i]; i++; end
            for (int k = 0; k < len; k++) begin
                if (!c[7]) begin v = stream[i]; i++; end
                w = {addr[17:0], v};
                if (addr <= 32'h3FFFF) em.push_back(w); else e_ovf_m = 1;
                if (addr <= 32'd3) es.push_back(w); else e_ovf_s = 1;
                addr++;
            end
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while ((m_wait || s_wait) && n < 400) begin
            tick();
            n++;
        end
        if (n == 400) chk({tag, "_ready_timeout"}, 32'(m_wait | s_wait), 32'd0);
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b);
        wait_ready(tag);
        ioctl_wr = 1'b1;
        ioctl_dout = b;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic start_image();
        image = 1'b1;
        tick();
    endtask

    task automatic compare_queues(input string tag);
        chk({tag, "_m_count"}, 32'(mq.size()), 32'(em.size()));
        for (int i = 0; i < mq.size() && i < em.size(); i++)
            chk($sformatf("%s_m_wr%0d", tag, i), 32'(mq[i]), 32'(em[i]));
        chk({tag, "_s_count"}, 32'(sq.size()), 32'(es.size()));
        for (int i = 0; i < sq.size() && i < es.size(); i++)
            chk($sformatf("%s_s_wr%0d", tag, i), 32'(sq[i]), 32'(es[i]));
        mq.delete(); sq.delete();
    endtask

    task automatic finish_and_check(input string tag, input bit exp_err);
        wait_ready(tag);
        repeat (2) tick();
        chk({tag, "_we_idle"}, 32'(m_we), 32'd0);
        chk({tag, "_done_before"}, 32'(m_done), 32'd0);
        image = 1'b0;
        repeat (2) tick();
        chk({tag, "_m_done"}, 32'(m_done), 32'd1);
        chk({tag, "_s_done"}, 32'(s_done), 32'd1);
        chk({tag, "_m_err"}, 32'(m_err), 32'(exp_err));
        chk({tag, "_s_err"}, 32'(s_err), 32'(exp_err));
        chk({tag, "_m_ovf"}, 32'(m_ovf), 32'(e_ovf_m));
        chk({tag, "_s_ovf"}, 32'(s_ovf), 32'(e_ovf_s));
        compare_queues(tag);
    endtask

    task automatic run_stream(input string tag);
        build_expect();
        start_image();
        foreach (stream[i]) send_byte(tag, stream[i]);
        finish_and_check(tag, 1'b0);
    endtask

    initial begin
        int n, bad, nr;
        logic [7:0] c;
        reset = 1'b1; image = 1'b0; ioctl_wr = 1'b0; ioctl_dout = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_we", 32'(m_we), 32'd0);
        chk("rst_addr", 32'(m_addr), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_wait", 32'(m_wait), 32'd0);
        chk("rst_done", 32'(m_done), 32'd0);
        chk("rst_ovf", 32'(m_ovf), 32'd0);
        chk("rst_err", 32'(m_err), 32'd0);

        // Literal run of three
        ack_mode = 0;
        stream = '{8'h02, 8'h0A, 8'h0B, 8'h0C};
        run_stream("literal");

        // Repeat run with slow ack; ioctl_wait must stay high through all four writes
        ack_mode = 1;
        stream = '{8'h83, 8'h55};
        build_expect();
        start_image();
        send_byte("repeat", 8'h83);
        send_byte("repeat", 8'h55);
        n = 0; bad = 0;
        while (mq.size() < 4 && n < 200) begin
            if (m_wait !== 1'b1) bad++;
            tick();
            n++;
        end
        chk("repeat_wait_held", 32'(bad), 32'd0);
        chk("repeat_wait_release", 32'(m_wait), 32'd0);
        finish_and_check("repeat", 1'b0);

        // Overflow on the tiny framebuffer
        ack_mode = 0;
        stream = '{8'h85, 8'h11};
        run_stream("overflow");
        chk("overflow_no_we_beyond", 32'(s_bad_we), 32'd0);

        // Truncation: image drops as the first repeat write is accepted
        ack_mode = 3; ack_man = 1'b0;
        tick();
        start_image();
        send_byte("trunc", 8'h83);
        send_byte("trunc", 8'h22);
        ack_man = 1'b1; image = 1'b0;
        tick();
        ack_man = 1'b0;
        repeat (3) tick();
        chk("trunc_we", 32'(m_we), 32'd0);
        chk("trunc_done", 32'(m_done), 32'd1);
        chk("trunc_err", 32'(m_err), 32'd1);
        chk("trunc_s_err", 32'(s_err), 32'd1);
        chk("trunc_m_count", 32'(mq.size()), 32'd1);
        chk("trunc_s_count", 32'(sq.size()), 32'd1);
        if (mq.size() > 0) chk("trunc_m_wr0", 32'(mq[0]), 32'h0000_0022);
        mq.delete(); sq.delete();

        // Byte pushed while a write awaits ack is dropped and flagged
        stream = '{8'h01, 8'hAA, 8'hBB};
        build_expect();
        start_image();
        send_byte("stall", 8'h01);
        send_byte("stall", 8'hAA);
        ioctl_wr = 1'b1; ioctl_dout = 8'hEE;
        tick();
        ioctl_wr = 1'b0; ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        send_byte("stall", 8'hBB);
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        finish_and_check("stall", 1'b1);

        // Reset in REP_WR with a pending write and a coincident ack
        start_image();
        send_byte("rst_mid", 8'h83);
        send_byte("rst_mid", 8'h77);
        reset = 1'b1; ack_man = 1'b1; image = 1'b0;
        tick();
        chk("rst_mid_we", 32'(m_we), 32'd0);
        chk("rst_mid_addr", 32'(m_addr), 32'd0);
        chk("rst_mid_data", 32'(m_data), 32'd0);
        chk("rst_mid_wait", 32'(m_wait), 32'd0);
        chk("rst_mid_done", 32'(m_done), 32'd0);
        chk("rst_mid_ovf", 32'(m_ovf), 32'd0);
        chk("rst_mid_err", 32'(m_err), 32'd0);
        reset = 1'b0; ack_man = 1'b0;
        tick();
        chk("rst_mid_no_write", 32'(mq.size()), 32'd0);
        mq.delete(); sq.delete();
        ack_mode = 0;
        stream = '{8'h00, 8'h99};
        run_stream("rst_restart");

        // Random complete streams under random ack behaviour
        for (int t = 0; t < 24; t++) begin
            ack_mode = int'($urandom_range(0, 2));
            stream.delete();
            nr = int'($urandom_range(1, 4));
            for (int r = 0; r < nr; r++) begin
                c = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 7))};
                stream.push_back(c);
                if (c[7]) stream.push_back(8'($urandom));
                else for (int k = 0; k <= int'(c[6:0]); k++) stream.push_back(8'($urandom));
            end
            run_stream($sformatf("rand%0d", t));
        end

        chk("handshake_stable", 32'(stab_bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
